// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Purpose : Shared constants and types for the register-file write path.
//           ADDR_WIDTH / DATA_WIDTH give the default register-file geometry,
//           ZERO_REG is the hard-wired zero register that is never written,
//           and wr_entry_t is one buffered write (address plus data).
// Ports   : none (package)
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;

    // Register 0 reads as zero, so writes aimed at it are dropped.
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// ----------------------------------------------------------------------------
// round_robin_arbiter
// Purpose : Picks one requester per cycle. The search begins at rr_ptr and
//           wraps around; the first asserted request wins. rr_ptr moves to
//           the slot after the winner only when the grant is taken up
//           (accept_i), so an unserved winner keeps its priority.
// Ports   : clock     - clock, state updates on posedge
//           reset     - asynchronous active-high reset (rr_ptr -> 0)
//           req_i     - request vector, one bit per requester
//           accept_i  - the granted requester completed a transfer
//           grant_o   - one-hot grant (all zero when nobody requests)
// ----------------------------------------------------------------------------
module round_robin_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] rr_ptr_d;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk the requesters starting at rr_ptr and grant the first active one.
    // The pointer that would follow this grant is computed alongside.
    always_comb begin
        grant_o  = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                rr_ptr_d     = PTR_W'((int'(idx) + 1) % NUM_REQ);
            end
        end
    end

    // Priority only rotates once a transfer actually happens.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else if (accept_i) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter
// Purpose : Shares the single register-file write port between NUM_REQ
//           writeback requesters. A round-robin arbiter picks one requester
//           per cycle; accepted writes land in a 2-entry FIFO that drains one
//           entry per cycle into the register file unless 'hold' is high.
//           Writes to register 0 complete their handshake but are dropped.
// Ports   : clock, reset       - clock and asynchronous active-high reset
//           req_valid          - requester i presents a write
//           req_ready          - requester i's write is accepted this cycle
//           req_address        - flattened addresses, slice i = requester i
//           req_data           - flattened data, slice i = requester i
//           hold               - freeze commits to the register file
//           write_enabled      - register-file write enable
//           write_address      - register-file write address (0 when empty)
//           write_data         - register-file write data (0 when empty)
//           pending_count      - number of buffered writes, 0..2
//           idle               - buffer empty and no request pending
// Config  : REGFILE_WRITE_ARBITER_FORWARD_EN adds two combinational lookup
//           ports (lookup_address_N -> lookup_hit_N / lookup_data_N) that
//           return the youngest buffered write to a given register.
// ----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          hold,
`ifdef REGFILE_WRITE_ARBITER_FORWARD_EN
    input  logic [ADDR_WIDTH-1:0]         lookup_address_1,
    input  logic [ADDR_WIDTH-1:0]         lookup_address_2,
    output logic                          lookup_hit_1,
    output logic                          lookup_hit_2,
    output logic [DATA_WIDTH-1:0]         lookup_data_1,
    output logic [DATA_WIDTH-1:0]         lookup_data_2,
`endif
    output logic                          write_enabled,
    output logic [ADDR_WIDTH-1:0]         write_address,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [1:0]                    pending_count,
    output logic                          idle
);

    import regfile_pkg::*;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    // Slot 0 is always the head (oldest); slot 1 is only meaningful at count 2.
    entry_t     entry_q [2];
    entry_t     entry_d [2];
    logic [1:0] count_q;
    logic [1:0] count_d;

    logic [NUM_REQ-1:0] grant;
    logic               popEn;
    logic               space;
    logic               transfer;
    logic               pushEn;
    entry_t             selEntry;

    round_robin_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .clock    (clock),
        .reset    (reset),
        .req_i    (req_valid),
        .accept_i (transfer),
        .grant_o  (grant)
    );

    // A slot opens up either because the FIFO is not full or because the head
    // leaves this same cycle, which is what sustains one write per cycle.
    always_comb begin
        popEn     = (count_q != 2'd0) && !hold;
        space     = (count_q < 2'd2) || popEn;
        req_ready = grant & {NUM_REQ{space}};
        transfer  = |(req_valid & req_ready);
    end

    // Pick the granted requester's slice. Writes to register 0 still finish
    // their handshake but never enter the FIFO.
    always_comb begin
        selEntry = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                selEntry.address = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                selEntry.data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        pushEn = transfer && (selEntry.address != ZERO_ADDR);
    end

    // Pop shifts slot 1 down to the head first; the push then lands in the
    // first free slot after the pop, which keeps acceptance order intact.
    always_comb begin
        entry_d[0] = entry_q[0];
        entry_d[1] = entry_q[1];
        count_d    = count_q;
        if (popEn) begin
            entry_d[0] = entry_q[1];
            count_d    = count_d - 2'd1;
        end
        if (pushEn) begin
            entry_d[count_d[0]] = selEntry;
            count_d             = count_d + 2'd1;
        end
    end

    // Reset empties the FIFO asynchronously so nothing buffered ever commits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            count_q    <= 2'd0;
        end else begin
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
            count_q    <= count_d;
        end
    end

    // Write port is driven straight from the head; zeros when nothing is queued.
    always_comb begin
        write_enabled = popEn;
        write_address = (count_q != 2'd0) ? entry_q[0].address : '0;
        write_data    = (count_q != 2'd0) ? entry_q[0].data : '0;
        pending_count = count_q;
        idle          = (count_q == 2'd0) && !(|req_valid);
    end

`ifdef REGFILE_WRITE_ARBITER_FORWARD_EN
    // Returns {hit, data}. Slot 1 is checked last so the younger write wins.
    function automatic logic [DATA_WIDTH:0] lookupEntry(
        input logic [ADDR_WIDTH-1:0] addr,
        input entry_t                head,
        input entry_t                tail,
        input logic [1:0]            count
    );
        logic [DATA_WIDTH:0] result;
        result = '0;
        if (addr != ZERO_ADDR) begin
            if ((count != 2'd0) && (head.address == addr)) begin
                result = {1'b1, head.data};
            end
            if ((count == 2'd2) && (tail.address == addr)) begin
                result = {1'b1, tail.data};
            end
        end
        return result;
    endfunction

    // Forwarding view of the buffered writes for the hazard logic.
    always_comb begin
        {lookup_hit_1, lookup_data_1} =
            lookupEntry(lookup_address_1, entry_q[0], entry_q[1], count_q);
        {lookup_hit_2, lookup_data_2} =
            lookupEntry(lookup_address_2, entry_q[0], entry_q[1], count_q);
    end
`endif

endmodule
